// File: rtl/div_unit.sv
// Iterative restoring radix-2 signed/unsigned divider feeding the HI/LO write path.
// Optional early-out for |divisor| > |dividend| is enabled by defining DIV_EARLY_OUT_EN.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_en_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StFinish
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic               dz_q;
    logic               skip_q;
    logic               done_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               div_by_zero_q;

    logic               dividend_neg;
    logic               divisor_neg;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic               divisor_zero;
    logic               early_out;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic               last_step;

    always_comb begin
        dividend_neg = signed_en_i & dividend_i[WIDTH-1];
        divisor_neg  = signed_en_i & divisor_i[WIDTH-1];
        dividend_mag = dividend_neg ? -dividend_i : dividend_i;
        divisor_mag  = divisor_neg ? -divisor_i : divisor_i;
        divisor_zero = (divisor_i == '0);
`ifdef DIV_EARLY_OUT_EN
        early_out    = !divisor_zero && (divisor_mag > dividend_mag);
`else
        early_out    = 1'b0;
`endif
    end

    // rem_q < dvsr_q always holds here, so the true difference lies in (-2^WIDTH, 2^WIDTH)
    // and bit WIDTH of the (WIDTH+1)-bit result is an exact borrow.
    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvsr_q};
        fits      = ~diff[WIDTH];
        rem_step  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], fits};
        quo_fin   = q_neg_q ? -quo_q : quo_q;
        rem_fin   = r_neg_q ? -rem_q : rem_q;
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            skip_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else if (cancel_i) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        cnt_q   <= '0;
                        dvsr_q  <= divisor_mag;
                        dz_q    <= divisor_zero;
                        skip_q  <= divisor_zero | early_out;
                        state_q <= StDivide;
                        if (divisor_zero) begin
                            // Results preloaded so FINISH yields all-ones / raw dividend.
                            rem_q   <= dividend_i;
                            quo_q   <= '1;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                        end else begin
                            rem_q   <= early_out ? dividend_mag : '0;
                            quo_q   <= early_out ? '0 : dividend_mag;
                            q_neg_q <= dividend_neg ^ divisor_neg;
                            r_neg_q <= dividend_neg;
                        end
                    end
                end
                StDivide: begin
                    // A skipped operation spends one cycle here without stepping.
                    if (skip_q) begin
                        state_q <= StFinish;
                    end else begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) begin
                            state_q <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    quotient_q    <= quo_fin;
                    remainder_q   <= rem_fin;
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = div_by_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: fixed vectors, multi-cycle corner sequences, random ops
// against an arithmetic reference model.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          signed_en;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          cancel;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .signed_en_i   (signed_en),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .cancel_i      (cancel),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit dz, output int lat);
        longint sa, sb, ma, mb;
        if (b == 0) begin
            q = '1;
            r = a;
            dz = 1'b1;
            lat = 2;
            return;
        end
        dz = 1'b0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            q  = a / b;
            r  = a % b;
        end
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        lat = 33;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) lat = 2;
`else
        if (mb > ma) lat = 33;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge (edge 0).
    task automatic pulse_start(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        signed_en = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts edges from the current negedge until done is seen (bounded).
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic check_op(input string name, input bit sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                            input bit edz, input int elat);
        int lat, bc;
        pulse_start(sgn, a, b);
        wait_done(lat, bc);
        chk({name, " quotient"}, quotient, eq);
        chk({name, " remainder"}, remainder, er);
        chk({name, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " busy cycles"}, 32'(bc), 32'(elat));
        @(negedge clk);
        chk({name, " done single pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int lat, bc, dones;
        logic [31:0] eq, er;
        bit edz;
        int elat;

        vecs[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33};
        vecs[1] = '{1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33};
        vecs[2] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 33};
        vecs[3] = '{1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 2};
        vecs[4] = '{0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 2};
`ifdef DIV_EARLY_OUT_EN
        vecs[5] = '{0, 32'd5, 32'd9, 32'd0, 32'd5, 0, 2};
`else
        vecs[5] = '{0, 32'd5, 32'd9, 32'd0, 32'd5, 0, 33};
`endif
        vecs[6] = '{1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 33};
        vecs[7] = '{0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 33};
        vecs[8] = '{1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 0, 33};

        rst_n = 1'b0;
        start = 1'b0;
        cancel = 1'b0;
        signed_en = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                     vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
        end

        // Reset mid-division clears every output.
        pulse_start(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset quotient", quotient, 32'd0);
        chk("midreset remainder", remainder, 32'd0);
        chk("midreset div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);

        // Start while busy is ignored.
        pulse_start(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        signed_en = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done(lat, bc);
        chk("busy-start latency", 32'(lat), 32'd28);
        chk("busy-start quotient", quotient, 32'd14);
        chk("busy-start remainder", remainder, 32'd2);
        repeat (3) @(negedge clk);
        chk("busy-start not queued", 32'(busy), 32'd0);

        // Cancel at cycle 10.
        pulse_start(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 32'(busy), 32'd0);
        chk("cancel done", 32'(done), 32'd0);
        chk("cancel quotient kept", quotient, 32'd14);
        chk("cancel remainder kept", remainder, 32'd2);
        check_op("after-cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // Start together with cancel in IDLE is ignored.
        signed_en = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        cancel    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cancel    = 1'b0;
        chk("start+cancel busy", 32'(busy), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("start+cancel no done", 32'(dones), 32'd0);
        chk("start+cancel quotient kept", quotient, 32'd3);

        for (int i = 0; i < 60; i++) begin
            bit sgn;
            logic [31:0] a, b;
            int sel;
            sgn = 1'($urandom % 2);
            a   = $urandom;
            sel = int'($urandom % 8);
            case (sel)
                0: b = 32'd0;
                1: b = $urandom % 16;
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                    sgn = 1'b1;
                end
                3: b = $urandom >> ($urandom % 32);
                4: begin
                    a = $urandom % 64;
                    b = $urandom % 128;
                end
                default: b = $urandom;
            endcase
            model(sgn, a, b, eq, er, edz, elat);
            check_op($sformatf("rand%0d", i), sgn, a, b, eq, er, edz, elat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised iterative signed/unsigned integer divider for the five-stage MIPS32 core. It serves `div`/`divu` and drives the HI/LO write path. It is started from EX and holds the pipeline through `busy` until it produces the quotient (LO) and remainder (HI). It replaces single-cycle division with a WIDTH-cycle restoring radix-2 engine that has a cancel path for pipeline flushes.

## Interface
Reset is synchronous and active-low.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_en  input  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- cancel  input  1  abort current operation (flush).
- busy  output  1  high whenever state ≠ IDLE; feeds the PipelineController stall request.
- done  output  1  single-cycle pulse; results valid.
- quotient  output  WIDTH  result to LO; held until next done.
- remainder  output  WIDTH  result to HI; held until next done.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

## Operation
- States: IDLE, DIVIDE, FINISH.
- IDLE: on start=1 and cancel=0:
  - latch the magnitudes of the operands (two's-complement absolute value if signed_en, else raw);
  - latch the result signs: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend); both are 0 when unsigned;
  - clear the partial remainder and counter;
  - go to DIVIDE, or go directly to FINISH if divisor == 0.
- DIVIDE: one restoring step per cycle:
  - shift {rem, quo} left by 1;
  - if rem ≥ |divisor|, subtract and set quo[0];
  - the counter increments; after the step with counter == WIDTH-1, go to FINISH.
- Subtraction uses a WIDTH+1-bit datapath, so no carry is lost.
- FINISH:
  - register quotient = q_neg ? -quo : quo;
  - register remainder = r_neg ? -rem : rem;
  - pulse done;
  - next state IDLE.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1.
- Overflow (signed, dividend = MIN, divisor = -1): quotient = MIN, remainder = 0. This is a natural wrap; no flag.
- start while busy: ignored, with no queueing.
- cancel in any state:
  - next state IDLE; done is not pulsed; quotient/remainder/div_by_zero keep their previous values;
  - cancel has priority over start in the same cycle.
- Reset (rst=0) at any edge, including mid-operation: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.

## Timing
- The edge that samples start is edge 0.
- busy is high from the cycle after edge 0 until the cycle after FINISH.
- Normal case: DIVIDE occupies edges 1..WIDTH; FINISH is entered at edge WIDTH.
  - done and the results are visible after edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- Divide by zero: FINISH is entered at edge 1; done is visible after edge 2.
- A new start is accepted in the cycle after done; back-to-back throughput is WIDTH+2 cycles.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- Macro `DIV_EARLY_OUT_EN`.
- Defined:
  - In IDLE, if divisor ≠ 0 and |divisor| > |dividend| (unsigned compare of the magnitudes), skip DIVIDE and go to FINISH with quo=0 and rem=|dividend|.
  - done is visible after edge 2.
  - Signs and the results are identical to the full path.
- Undefined: every nonzero-divisor operation takes the full WIDTH iterations. The comparator logic is absent.

## Test plan
- Unsigned 100 / 7, WIDTH=32 → quotient=14, remainder=2, div_by_zero=0, done exactly 33 cycles after the start edge, busy high for 33 cycles.
- Signed -7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: 0x1234 / 0 (signed and unsigned) → quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, done after edge 2.
- cancel at cycle 10 of 100/7:
  - busy low next cycle, no done, outputs keep the prior results;
  - an immediate new start of 9/3 → quotient=3, remainder=0;
  - start asserted together with cancel in IDLE is ignored.
- rst=0 at cycle 15 mid-division → all outputs 0 next cycle. start raised while busy is ignored and the results match the first operation.
- 5 / 9 unsigned → quotient=0, remainder=5. done after 2 cycles with `DIV_EARLY_OUT_EN` defined, 33 cycles without.
